// File: rtl/sign_mag_pkg.sv
// ---------------------------------------------------------------------------
// sign_mag_pkg
// Shared definitions for the int8 sign-magnitude <-> two's complement lanes.
//   LANE_W     : width of one packed lane (8 bits)
//   lane_t     : one lane
//   NEG_ZERO   : the sign-magnitude "-0" encoding (0x80)
//   sm_to_tc() : sign-magnitude lane -> two's complement lane
//   tc_to_sm() : two's complement lane -> sign-magnitude lane (the packing side;
//                -128 has no sign-magnitude form and is clamped to -127)
// ---------------------------------------------------------------------------
package sign_mag_pkg;

  localparam int unsigned LANE_W = 8;

  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t NEG_ZERO = 8'h80;

  // y = s ? -m : m, computed in 8 bits. Magnitudes are at most 127, so the
  // result always fits; -0 folds onto +0.
  function automatic lane_t sm_to_tc(input lane_t x);
    lane_t mag;
    mag = {1'b0, x[6:0]};
    return x[7] ? (~mag + 8'd1) : mag;
  endfunction

  // Inverse packing. -128 (0x80) cannot be represented and becomes 0xFF (-127).
  function automatic lane_t tc_to_sm(input lane_t x);
    lane_t mag;
    if (x == 8'h80) begin
      mag = 8'h7F;
    end else if (x[7]) begin
      mag = ~x + 8'd1;
    end else begin
      mag = x;
    end
    return {x[7], mag[6:0]};
  endfunction

endpackage

// File: rtl/sign_mag_lane_to_tc.sv
// ---------------------------------------------------------------------------
// sign_mag_lane_to_tc
// Purely combinational conversion of one sign-magnitude int8 lane into its
// two's complement value.
// Ports:
//   sm_i : sign-magnitude lane in  (bit 7 = sign, bits 6:0 = magnitude)
//   tc_o : two's complement lane out
// ---------------------------------------------------------------------------
module sign_mag_lane_to_tc
  import sign_mag_pkg::*;
(
  input  lane_t sm_i,
  output lane_t tc_o
);

  assign tc_o = sm_to_tc(sm_i);

endmodule

// File: rtl/sign_mag_to_twos_complement_stream.sv
// ---------------------------------------------------------------------------
// sign_mag_to_twos_complement_stream
// Streaming converter from packed sign-magnitude int8 lanes to packed two's
// complement lanes. One-cycle latency, full throughput, 2-entry skid buffer
// (main register drives the output, skid register absorbs one word while the
// output is stalled so in_ready_o can be a pure register).
//
// Optional feature macro: SM2TC_STATS_EN
//   defined     : word_cnt_o / neg_zero_cnt_o count accepted words and accepted
//                 -0 (0x80) lanes, wrapping, cleared only by reset.
//   not defined : no counter logic, both counter ports tied to 0.
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous reset, active low
//   clear_i        : synchronous flush of both buffer entries
//   in_valid_i     : input word valid
//   in_ready_o     : converter can accept a word (registered)
//   in_data_i      : packed sign-magnitude lanes, lane i = [i*8 +: 8]
//   out_valid_o    : output word valid
//   out_ready_i    : downstream accepts
//   out_data_o     : packed two's complement lanes
//   neg_zero_cnt_o : count of accepted 0x80 lanes
//   word_cnt_o     : count of accepted words
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. Once out_valid_o is high it stays high and
// out_data_o stays constant until out_ready_i is seen high (clear_i and reset
// excepted). While clear_i is high no input word is taken, whatever
// in_ready_o shows.
// ---------------------------------------------------------------------------
module sign_mag_to_twos_complement_stream
  import sign_mag_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [NUM_LANES*LANE_W-1:0]    in_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NUM_LANES*LANE_W-1:0]    out_data_o,
  output logic [CNT_WIDTH-1:0]           neg_zero_cnt_o,
  output logic [CNT_WIDTH-1:0]           word_cnt_o
);

  localparam int unsigned DATA_W = NUM_LANES * LANE_W;

  // -------------------------------------------------------------------------
  // Lane conversion, ahead of storage: both buffer entries hold converted data.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] conv_data;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sign_mag_lane_to_tc u_lane (
      .sm_i (in_data_i[g*LANE_W +: LANE_W]),
      .tc_o (conv_data[g*LANE_W +: LANE_W])
    );
  end

  // -------------------------------------------------------------------------
  // Skid buffer
  // -------------------------------------------------------------------------
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic accept;     // input handshake completes this edge
  logic main_free;  // main register is empty or being emptied this edge

  assign accept    = in_valid_i && in_ready_o && !clear_i;
  assign main_free = !main_valid_q || out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (clear_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Older word in skid moves forward first to preserve order.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = conv_data;
        end
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_data_d = conv_data;
        end
      end
    end else if (accept) begin
      // Output stalled with main full: the word parks in skid, which is
      // necessarily empty because in_ready_o was high.
      skid_valid_d = 1'b1;
      skid_data_d  = conv_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // Ready depends only on state, never combinationally on out_ready_i.
  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
`ifdef SM2TC_STATS_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] neg_zero_cnt_q, neg_zero_cnt_d;
  logic [CNT_WIDTH-1:0] nz_in_word;

  // Number of -0 lanes in the raw input word (0..NUM_LANES).
  always_comb begin
    nz_in_word = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (in_data_i[i*LANE_W +: LANE_W] == NEG_ZERO) begin
        nz_in_word = nz_in_word + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    word_cnt_d     = word_cnt_q;
    neg_zero_cnt_d = neg_zero_cnt_q;
    if (accept) begin
      word_cnt_d     = word_cnt_q + CNT_WIDTH'(1);
      neg_zero_cnt_d = neg_zero_cnt_q + nz_in_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_cnt_q     <= '0;
      neg_zero_cnt_q <= '0;
    end else begin
      word_cnt_q     <= word_cnt_d;
      neg_zero_cnt_q <= neg_zero_cnt_d;
    end
  end

  assign word_cnt_o     = word_cnt_q;
  assign neg_zero_cnt_o = neg_zero_cnt_q;
`else
  assign word_cnt_o     = '0;
  assign neg_zero_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sign_mag_to_twos_complement_stream.sv
// ---------------------------------------------------------------------------
// tb_sign_mag_to_twos_complement_stream
// Self-checking bench: table vectors, exhaustive lane sweep, TC->SM->TC round
// trip, backpressure, random valid/ready stream, clear and async reset.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_sign_mag_to_twos_complement_stream;
  import sign_mag_pkg::*;

  localparam int NUM_LANES = 4;
  localparam int W         = NUM_LANES * 8;
  localparam int CNT_W     = 32;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic             clk;
  logic             rst_n;
  logic             clear_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [W-1:0]     in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [W-1:0]     out_data_o;
  logic [CNT_W-1:0] neg_zero_cnt_o;
  logic [CNT_W-1:0] word_cnt_o;

  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  sign_mag_to_twos_complement_stream #(
    .NUM_LANES (NUM_LANES),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .neg_zero_cnt_o (neg_zero_cnt_o),
    .word_cnt_o     (word_cnt_o)
  );

  // -------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on sign and magnitude.
  // -------------------------------------------------------------------------
  function automatic logic [W-1:0] ref_word(input logic [W-1:0] w);
    logic [W-1:0] r;
    int m;
    int v;
    for (int k = 0; k < NUM_LANES; k++) begin
      m = int'(w[k*8 +: 7]);
      v = w[k*8+7] ? -m : m;
      r[k*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  function automatic int ref_nz(input logic [W-1:0] w);
    int n = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (w[k*8 +: 8] == 8'h80) n++;
    end
    return n;
  endfunction

  // Random word with extra weight on the -0 and extreme encodings.
  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    int sel;
    for (int k = 0; k < NUM_LANES; k++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       w[k*8 +: 8] = 8'h80;
        1:       w[k*8 +: 8] = 8'hFF;
        2:       w[k*8 +: 8] = 8'h7F;
        default: w[k*8 +: 8] = 8'($urandom);
      endcase
    end
    return w;
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] m_words;
  logic [CNT_W-1:0] m_nz;
  int               n_checks = 0;
  int               n_errs   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cnts(input string name);
`ifdef SM2TC_STATS_EN
    check({name, "_word_cnt"}, 64'(word_cnt_o), 64'(m_words));
    check({name, "_nz_cnt"},   64'(neg_zero_cnt_o), 64'(m_nz));
`else
    check({name, "_word_cnt"}, 64'(word_cnt_o), 64'd0);
    check({name, "_nz_cnt"},   64'(neg_zero_cnt_o), 64'd0);
`endif
  endtask

  // Observes both interfaces at every falling edge.
  task automatic monitor();
    logic         prev_stall = 1'b0;
    logic         prev_clr   = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_words    = '0;
        m_nz       = '0;
        prev_stall = 1'b0;
        prev_clr   = 1'b0;
        continue;
      end
      if (prev_stall && !prev_clr) begin
        check("stall_valid_held", 64'(out_valid_o), 64'd1);
        check("stall_data_held",  64'(out_data_o),  64'(prev_data));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 64'(out_data_o), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 64'(out_data_o), 64'(e));
        end
      end
      if (clear_i) begin
        exp_q.delete();
      end else if (in_valid_i && in_ready_o) begin
        exp_q.push_back(ref_word(in_data_i));
        m_words = m_words + 1;
        m_nz    = m_nz + CNT_W'(ref_nz(in_data_i));
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_clr   = clear_i;
      prev_data  = out_data_o;
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (called at 1ns after a rising edge, return at the same phase)
  // -------------------------------------------------------------------------
  task automatic drive_word(input logic [W-1:0] d);
    int n = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    @(negedge clk);
    while (!(in_ready_o && !clear_i) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drive_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send_check(input string name, input logic [W-1:0] d, input logic [W-1:0] exp);
    out_ready_i = 1'b1;
    drive_word(d);
    @(negedge clk);
    check({name, "_valid"}, 64'(out_valid_o), 64'd1);
    check({name, "_data"},  64'(out_data_o),  64'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b0;
    @(negedge clk);
    #1;
    while ((exp_q.size() != 0 || out_valid_o) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid",   64'(out_valid_o),  64'd0);
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] in_w;
    logic [W-1:0] exp_w;
  } vec_t;

  vec_t vecs[7];

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [W-1:0]     w;
    logic [W-1:0]     e;
    logic [W-1:0]     bp_words[8];
    logic [CNT_W-1:0] base_words;
    logic [CNT_W-1:0] save_wc;
    logic [CNT_W-1:0] save_nz;
    logic [7:0]       lv;
    logic [7:0]       le;
    int               t0;
    int               v;
    bit               done;

    vecs[0] = '{32'h80FF7F01, 32'h00817F01};
    vecs[1] = '{32'h00000000, 32'h00000000};
    vecs[2] = '{32'h81FE4001, 32'hFF824001};
    vecs[3] = '{32'hC08A7E80, 32'hC0F67E00};
    vecs[4] = '{32'hFFFFFFFF, 32'h81818181};
    vecs[5] = '{32'h80808080, 32'h00000000};
    vecs[6] = '{32'h7F7F7F7F, 32'h7F7F7F7F};

    m_words     = '0;
    m_nz        = '0;
    rst_n       = 1'b0;
    clear_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;

    fork
      monitor();
    join_none

    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_out_data",  64'(out_data_o),  64'd0);
    check("rst_in_ready",  64'(in_ready_o),  64'd1);
    check("rst_word_cnt",  64'(word_cnt_o),  64'd0);
    check("rst_nz_cnt",    64'(neg_zero_cnt_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single word, then counters
    send_check("single", vecs[0].in_w, vecs[0].exp_w);
`ifdef SM2TC_STATS_EN
    check("single_word_cnt", 64'(word_cnt_o), 64'd1);
    check("single_nz_cnt",   64'(neg_zero_cnt_o), 64'd1);
`else
    check("single_word_cnt", 64'(word_cnt_o), 64'd0);
    check("single_nz_cnt",   64'(neg_zero_cnt_o), 64'd0);
`endif

    // Table vectors
    for (int i = 1; i < 7; i++) begin
      send_check($sformatf("vec%0d", i), vecs[i].in_w, vecs[i].exp_w);
    end
    drain();

    // 2a: every lane sees all 256 encodings, streamed back to back
    out_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
      drive_word(w);
    end
    drain();
    check_cnts("exhaustive");

    // 2b: TC -> SM (packing side) -> DUT -> TC round trip
    for (int base = -128; base < 128; base += 4) begin
      for (int k = 0; k < 4; k++) begin
        v  = base + k;
        lv = 8'(v);
        w[k*8 +: 8] = tc_to_sm(lv);
        le = (v == -128) ? 8'h81 : lv;
        e[k*8 +: 8] = le;
      end
      send_check($sformatf("roundtrip_%0d", base), w, e);
    end
    drain();

    // 3: backpressure with 8 back-to-back words, 3 stalled cycles
    for (int i = 0; i < 8; i++) bp_words[i] = rand_word();
    base_words  = m_words;
    out_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_word(bp_words[i]);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("bp_in_ready_low",  64'(in_ready_o),  64'd0);
        check("bp_accepted_two",  64'(m_words - base_words), 64'd2);
        check("bp_out_first",     64'(out_data_o),  64'(ref_word(bp_words[0])));
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
      end
    join
    drain();
    check("bp_all_accepted", 64'(m_words - base_words), 64'd8);

    // 4a: full rate while out_ready stays high
    out_ready_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 200; i++) drive_word(rand_word());
    check("full_rate_cycles", 64'(cyc - t0), 64'd200);
    drain();

    // 4b: random valid/ready, 10k words
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          drive_word(rand_word());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    check_cnts("random");

    // 5: clear with main and skid full and a word offered
    out_ready_i = 1'b0;
    drive_word(rand_word());
    drive_word(rand_word());
    check("clr_pre_in_ready", 64'(in_ready_o), 64'd0);
    save_wc    = word_cnt_o;
    save_nz    = neg_zero_cnt_o;
    in_valid_i = 1'b1;
    in_data_i  = 32'h80808080;
    clear_i    = 1'b1;
    @(posedge clk);
    #1;
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    check("clr_out_valid", 64'(out_valid_o), 64'd0);
    check("clr_in_ready",  64'(in_ready_o),  64'd1);
    check("clr_word_cnt",  64'(word_cnt_o),  64'(save_wc));
    check("clr_nz_cnt",    64'(neg_zero_cnt_o), 64'(save_nz));
    out_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("clr_no_ghost", 64'(out_valid_o), 64'd0);
    @(posedge clk);
    #1;
    drain();
    check_cnts("clear");

    // 6: asynchronous reset mid-stream
    out_ready_i = 1'b0;
    drive_word(rand_word());
    drive_word(rand_word());
    in_valid_i = 1'b1;
    in_data_i  = rand_word();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid_o), 64'd0);
    check("arst_out_data",  64'(out_data_o),  64'd0);
    check("arst_in_ready",  64'(in_ready_o),  64'd1);
    check("arst_word_cnt",  64'(word_cnt_o),  64'd0);
    check("arst_nz_cnt",    64'(neg_zero_cnt_o), 64'd0);
    in_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) drive_word(rand_word());
    drain();
    check_cnts("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
